// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
// Reads back a multiplexed, active-low seven-segment display bus and
// reconstructs the hex digit shown at each scanned position. A frame is
// published only after it has been seen identically for STABLE_FRAMES scans,
// and only if it differs from the last published frame.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_seg        segments, active-low, [0]=a .. [6]=g
//   i_digit_en   digit enables, active-low, one-hot-low while scanning
//   i_ready      consumer accepts the published result
//   o_valid      published result available
//   o_digits     o_digits[4k+3:4k] = hex value read at position k
//   o_blank      position k showed all segments off
//   o_bad_code   position k showed a pattern that is not a hex glyph
//   o_overrun    sticky: a stable result was dropped while o_valid & !i_ready
//   o_timeout    one-cycle pulse: frame abandoned after TIMEOUT cycles
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
   parameter int N_DIGITS      = 4,
   parameter int SETTLE        = 4,
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT       = 4096
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [6:0]            i_seg,
   input  logic [N_DIGITS-1:0]   i_digit_en,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [4*N_DIGITS-1:0] o_digits,
   output logic [N_DIGITS-1:0]   o_blank,
   output logic [N_DIGITS-1:0]   o_bad_code,
   output logic                  o_overrun,
   output logic                  o_timeout
);

   localparam int IW = $clog2(N_DIGITS + 1);
   localparam int CW = $clog2(SETTLE + 1);
   localparam int MW = $clog2(STABLE_FRAMES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = 6 * N_DIGITS;

   typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_CHECK} state_t;

   // Returns {bad, blank, nibble}
   function automatic logic [5:0] f_decode(input logic [6:0] seg);
      logic [5:0] res;
      res = 6'b10_0000;
      case (seg)
         7'h40: res = 6'h00;  7'h79: res = 6'h01;  7'h24: res = 6'h02;  7'h30: res = 6'h03;
         7'h19: res = 6'h04;  7'h12: res = 6'h05;  7'h02: res = 6'h06;  7'h78: res = 6'h07;
         7'h00: res = 6'h08;  7'h10: res = 6'h09;  7'h08: res = 6'h0A;  7'h03: res = 6'h0B;
         7'h46: res = 6'h0C;  7'h21: res = 6'h0D;  7'h06: res = 6'h0E;  7'h0E: res = 6'h0F;
         7'h7F: res = 6'b01_0000;
         default: res = 6'b10_0000;
      endcase
      return res;
   endfunction

   // Settle tracking
   logic          w_sel_vld;
   logic [IW-1:0] w_sel_idx;
   logic          w_same_sel;
   logic          w_same;
   logic          w_captured_eff;
   logic          w_capture;
   logic [CW-1:0] w_settle_nxt;
   logic [6:0]    r_prev_seg;
   logic          r_prev_sel_vld;
   logic [IW-1:0] r_prev_idx;
   logic [CW-1:0] r_settle_cnt;
   logic          r_captured;

   // Frame assembly and FSM
   logic [6:0]            r_slot [N_DIGITS];
   logic [4*N_DIGITS-1:0] w_dig;
   logic [N_DIGITS-1:0]   w_blank;
   logic [N_DIGITS-1:0]   w_bad;
   logic [FW-1:0]         w_frame;
   state_t                r_state, w_state_nxt;
   logic [IW-1:0]         r_expect, w_expect_nxt;
   logic [TW-1:0]         r_timer, w_timer_nxt;
   logic [MW-1:0]         r_match, w_match_nxt;
   logic [FW-1:0]         r_prev_frame;
   logic                  w_check;
   logic                  w_timeout;
   logic                  w_publish;

   // Publish side
   logic                  r_valid;
   logic [4*N_DIGITS-1:0] r_digits;
   logic [N_DIGITS-1:0]   r_blank;
   logic [N_DIGITS-1:0]   r_bad;
   logic                  r_overrun;
   logic                  r_timeout;
   logic [FW-1:0]         r_pub_frame;
   logic                  r_pub_any;

   // Position k is selected only when exactly its enable is low.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (i_digit_en == ~(N_DIGITS'(1) << k)) begin
            w_sel_vld = 1'b1;
            w_sel_idx = IW'(k);
         end
      end
   end

   assign w_same_sel = w_sel_vld && r_prev_sel_vld && (w_sel_idx == r_prev_idx);
   assign w_same     = w_same_sel && (i_seg == r_prev_seg);

   // The count includes the first cycle of a run, so it reaches SETTLE on the
   // SETTLE-th identical cycle. A Seg change inside the window restarts the
   // count but cannot re-arm a capture; only a new selection does that.
   always_comb begin
      w_settle_nxt = '0;
      if (w_sel_vld) begin
         if (!w_same)                              w_settle_nxt = CW'(1);
         else if (r_settle_cnt == CW'(SETTLE))     w_settle_nxt = r_settle_cnt;
         else                                      w_settle_nxt = r_settle_cnt + CW'(1);
      end
   end

   assign w_captured_eff = w_same_sel ? r_captured : 1'b0;
   assign w_capture      = w_sel_vld && !w_captured_eff && (w_settle_nxt == CW'(SETTLE));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_seg     <= '0;
         r_prev_sel_vld <= 1'b0;
         r_prev_idx     <= '0;
         r_settle_cnt   <= '0;
         r_captured     <= 1'b0;
      end else begin
         r_prev_seg     <= i_seg;
         r_prev_sel_vld <= w_sel_vld;
         r_prev_idx     <= w_sel_idx;
         r_settle_cnt   <= w_settle_nxt;
         r_captured     <= w_captured_eff | w_capture;
      end
   end

   always_comb begin
      logic [5:0] v_dec;
      v_dec   = '0;
      w_dig   = '0;
      w_blank = '0;
      w_bad   = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         v_dec           = f_decode(r_slot[k]);
         w_dig[4*k +: 4] = v_dec[3:0];
         w_blank[k]      = v_dec[4];
         w_bad[k]        = v_dec[5];
      end
   end

   assign w_frame = {w_bad, w_blank, w_dig};

   always_comb begin
      w_state_nxt  = r_state;
      w_expect_nxt = r_expect;
      w_timer_nxt  = r_timer;
      w_match_nxt  = r_match;
      w_check      = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_HUNT: begin
            if (w_capture && (w_sel_idx == '0)) begin
               w_expect_nxt = IW'(1);
               w_timer_nxt  = '0;
               w_state_nxt  = (N_DIGITS == 1) ? S_CHECK : S_COLLECT;
            end
         end
         S_COLLECT: begin
            w_timer_nxt = (r_timer == TW'(TIMEOUT)) ? r_timer : r_timer + TW'(1);
            if (w_capture) begin
               if (w_sel_idx != r_expect) begin
                  w_state_nxt = S_HUNT;
                  w_match_nxt = '0;
               end else if (r_expect == IW'(N_DIGITS - 1)) begin
                  w_state_nxt = S_CHECK;
               end else begin
                  w_expect_nxt = r_expect + IW'(1);
               end
            end else if (r_timer >= TW'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th cycle spent collecting.
               w_timeout   = 1'b1;
               w_state_nxt = S_HUNT;
               w_match_nxt = '0;
            end
         end
         S_CHECK: begin
            w_check     = 1'b1;
            w_state_nxt = S_HUNT;
            if (w_frame != r_prev_frame)               w_match_nxt = MW'(1);
            else if (r_match == MW'(STABLE_FRAMES))    w_match_nxt = r_match;
            else                                       w_match_nxt = r_match + MW'(1);
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

   assign w_publish = w_check && (w_match_nxt == MW'(STABLE_FRAMES)) &&
                      (!r_pub_any || (w_frame != r_pub_frame));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_HUNT;
         r_expect     <= '0;
         r_timer      <= '0;
         r_match      <= '0;
         r_prev_frame <= '0;
         for (int k = 0; k < N_DIGITS; k++) r_slot[k] <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_expect <= w_expect_nxt;
         r_timer  <= w_timer_nxt;
         r_match  <= w_match_nxt;
         if (w_check) r_prev_frame <= w_frame;
         for (int k = 0; k < N_DIGITS; k++) begin
            if (w_capture && (w_sel_idx == IW'(k))) r_slot[k] <= i_seg;
         end
      end
   end

   // A drop while stalled is not remembered as published, so the same frame
   // is offered again on the next stable check.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid     <= 1'b0;
         r_digits    <= '0;
         r_blank     <= '0;
         r_bad       <= '0;
         r_overrun   <= 1'b0;
         r_timeout   <= 1'b0;
         r_pub_frame <= '0;
         r_pub_any   <= 1'b0;
      end else begin
         r_timeout <= w_timeout;
         if (r_valid && i_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
         if (w_publish) begin
            if (!r_valid || i_ready) begin
               r_valid     <= 1'b1;
               r_digits    <= w_dig;
               r_blank     <= w_blank;
               r_bad       <= w_bad;
               r_pub_frame <= w_frame;
               r_pub_any   <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_digits   = r_digits;
   assign o_blank    = r_blank;
   assign o_bad_code = r_bad;
   assign o_overrun  = r_overrun;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
// Directed scenarios followed by randomized displays. Expected results come
// from a frame-level model: each scanned frame is decoded by table lookup,
// the run of identical frames is counted, and publish/handshake outcomes are
// derived per frame.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

   localparam int N  = 4;
   localparam int ST = 4;
   localparam int SF = 2;
   localparam int TO = 4096;

   localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam logic [6:0] BADS [3] = '{7'h7E, 7'h55, 7'h7D};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    seg;
   logic [N-1:0]  den;
   logic          ready;
   logic          o_valid;
   logic [4*N-1:0] o_digits;
   logic [N-1:0]  o_blank;
   logic [N-1:0]  o_bad_code;
   logic          o_overrun;
   logic          o_timeout;

   always #5 clk = ~clk;

   seg7_scan_reader #(.N_DIGITS(N), .SETTLE(ST), .STABLE_FRAMES(SF), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_seg(seg), .i_digit_en(den), .i_ready(ready),
      .o_valid(o_valid), .o_digits(o_digits), .o_blank(o_blank), .o_bad_code(o_bad_code),
      .o_overrun(o_overrun), .o_timeout(o_timeout)
   );

   int vectors = 0;
   int errors  = 0;

   // Monitor
   int          mon_pulses;
   int          mon_to;
   logic [23:0] mon_val;

   // Model
   logic        m_valid, m_overrun, m_have_prev, m_pub_any;
   int          m_match;
   logic [23:0] m_prev, m_last_pub, m_out;

   logic [6:0]  fr [N];
   int          ord [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (o_valid && ready) begin
         mon_pulses++;
         mon_val = {o_bad_code, o_blank, o_digits};
      end
      if (o_timeout) mon_to++;
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_pulses = 0;
      mon_to     = 0;
      mon_val    = '0;
   endtask

   task automatic model_reset();
      m_valid = 0; m_overrun = 0; m_have_prev = 0; m_pub_any = 0; m_match = 0;
      m_prev = '0; m_last_pub = '0; m_out = '0;
   endtask

   // {bad[3:0], blank[3:0], digits[15:0]} of what the bench is displaying
   function automatic logic [23:0] model_frame();
      logic [23:0] f;
      bit hit;
      f = '0;
      for (int k = 0; k < N; k++) begin
         hit = 0;
         for (int g = 0; g < 16; g++) begin
            if (fr[k] == GLYPH[g]) begin
               f[4*k +: 4] = 4'(g);
               hit = 1;
            end
         end
         if (!hit) begin
            if (fr[k] == 7'h7F) f[16 + k] = 1'b1;
            else                f[20 + k] = 1'b1;
         end
      end
      return f;
   endfunction

   task automatic set_disp(input int a, input int b, input int c, input int d);
      fr[0] = GLYPH[a]; fr[1] = GLYPH[b]; fr[2] = GLYPH[c]; fr[3] = GLYPH[d];
   endtask

   task automatic scan_frame(input int cpd, input logic rdy, input string tag);
      int          exp_p;
      bit          in_order;
      logic [23:0] f;
      mon_clear();
      for (int p = 0; p < N; p++) begin
         den   = ~(4'b0001 << ord[p]);
         seg   = fr[ord[p]];
         ready = rdy;
         repeat (cpd) tick();
      end
      exp_p = 0;
      if (m_valid && rdy) begin
         exp_p++;
         m_valid   = 0;
         m_overrun = 0;
      end
      in_order = 1;
      for (int p = 0; p < N; p++) if (ord[p] != p) in_order = 0;
      if (!in_order) begin
         m_match = 0;
      end else begin
         f = model_frame();
         if (m_have_prev && f == m_prev) m_match = (m_match + 1 > SF) ? SF : m_match + 1;
         else                            m_match = 1;
         m_have_prev = 1;
         m_prev      = f;
         if (m_match == SF && (!m_pub_any || f != m_last_pub)) begin
            if (!m_valid) begin
               m_out      = f;
               m_last_pub = f;
               m_pub_any  = 1;
               if (rdy) exp_p++;
               else     m_valid = 1;
            end else begin
               m_overrun = 1;
            end
         end
      end
      chk({tag, "/pulses"}, mon_pulses, exp_p);
      if (exp_p > 0) chk({tag, "/value"}, mon_val, m_out);
      chk({tag, "/valid"}, o_valid, m_valid);
      chk({tag, "/overrun"}, o_overrun, m_overrun);
      chk({tag, "/timeout"}, mon_to, 0);
      if (m_valid) chk({tag, "/held"}, {o_bad_code, o_blank, o_digits}, m_out);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_e, to_cyc, nfr, cpd, r;
      logic rdy;

      for (int p = 0; p < N; p++) ord[p] = p;
      model_reset();
      rst_n = 0; den = '1; seg = 7'h7F; ready = 1;
      repeat (3) tick();
      chk("reset/outputs", {o_valid, o_overrun, o_timeout, o_bad_code, o_blank, o_digits}, '0);
      rst_n = 1;
      tick();

      // 1: "1234" twice
      set_disp(1, 2, 3, 4);
      scan_frame(8, 1, "t1f1");
      scan_frame(8, 1, "t1f2");
      chk("t1/digits", mon_val[15:0], 16'h4321);
      chk("t1/flags", mon_val[23:16], 8'h00);

      // 2: no republish, then blank position 3
      for (int i = 0; i < 5; i++) scan_frame(8, 1, "t2same");
      fr[3] = 7'h7F;
      scan_frame(8, 1, "t2blk1");
      scan_frame(8, 1, "t2blk2");
      chk("t2/digits", mon_val[15:0], 16'h0321);
      chk("t2/blank", mon_val[19:16], 4'b1000);

      // 3: bad glyph at position 2, then a stuck position 1 that times out
      set_disp(1, 2, 0, 4);
      fr[2] = 7'h7E;
      scan_frame(8, 1, "t3bad1");
      scan_frame(8, 1, "t3bad2");
      chk("t3/bad", mon_val[23:20], 4'b0100);
      chk("t3/digits", mon_val[15:0], 16'h4021);
      mon_clear();
      first_e = -1; to_cyc = 0;
      den = 4'b1110; seg = 7'h79; ready = 1;
      for (int e = 0; e < 4200; e++) begin
         if (e >= 8) begin
            den = 4'b1101;
            seg = (((e - 8) / 2) % 2 == 1) ? 7'h24 : 7'h30;
         end
         tick();
         if (o_timeout) begin
            if (first_e < 0) first_e = e;
            to_cyc++;
         end
      end
      m_match = 0;
      chk("t3/timeout_edge", first_e, 3 + TO);
      chk("t3/timeout_width", to_cyc, 1);
      chk("t3/no_publish", mon_pulses, 0);

      // 4: stalled consumer, display changes -> overrun
      set_disp(1, 2, 3, 4);
      scan_frame(8, 0, "t4a");
      scan_frame(8, 0, "t4b");
      set_disp(5, 6, 7, 8);
      scan_frame(8, 0, "t4c");
      scan_frame(8, 0, "t4d");
      chk("t4/overrun", o_overrun, 1'b1);
      chk("t4/digits_held", o_digits, 16'h4321);
      den = '1; seg = 7'h7F; ready = 1;
      tick();
      m_valid = 0; m_overrun = 0;
      chk("t4/valid_after_ready", o_valid, 1'b0);
      chk("t4/overrun_after_ready", o_overrun, 1'b0);

      // 5: out-of-order scan never publishes
      ord[0] = 0; ord[1] = 2; ord[2] = 1; ord[3] = 3;
      for (int i = 0; i < 3; i++) scan_frame(8, 1, "t5");
      for (int p = 0; p < N; p++) ord[p] = p;

      // 6: asynchronous reset in the middle of a frame
      set_disp(9, 10, 11, 12);
      scan_frame(8, 0, "t6a");
      scan_frame(8, 0, "t6b");
      ready = 0;
      den = 4'b1110; seg = fr[0]; repeat (8) tick();
      den = 4'b1101; seg = fr[1]; repeat (8) tick();
      chk("t6/valid_before_reset", o_valid, 1'b1);
      #2 rst_n = 0;
      #1;
      chk("t6/async_reset", {o_valid, o_overrun, o_timeout, o_bad_code, o_blank, o_digits}, '0);
      den = '1; seg = 7'h7F;
      repeat (2) tick();
      rst_n = 1;
      model_reset();
      tick();
      scan_frame(8, 1, "t6c");
      scan_frame(8, 1, "t6d");
      chk("t6/digits", mon_val[15:0], 16'hCBA9);

      // Randomized displays, frame counts, scan speeds and consumer stalls
      for (int it = 0; it < 30; it++) begin
         if (it == 0 || $urandom_range(0, 3) != 0) begin
            for (int k = 0; k < N; k++) begin
               r = $urandom_range(0, 17);
               if (r < 16)       fr[k] = GLYPH[r];
               else if (r == 16) fr[k] = 7'h7F;
               else              fr[k] = BADS[$urandom_range(0, 2)];
            end
         end
         nfr = $urandom_range(1, 3);
         cpd = $urandom_range(7, 12);
         for (int f = 0; f < nfr; f++) begin
            rdy = ($urandom_range(0, 3) != 0);
            scan_frame(cpd, rdy, "rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
